vga_timing_ctrl_param: RTL and testbench

- Parametrised VGA timing generator and pixel fetcher; successor to the fixed 640x480 controller.
- Timing, sync polarity, colour depth and address widths are set by parameters.
- Adds a data-enable output, sync outputs aligned to the colour pipeline, frame/line strobes and a frame counter.
- Sits between the pixel RAM (read through row_addr/col_addr/rdn) and the VGA connector.

---
 rtl/vga_timing_ctrl_param_if.sv | 32 +++
 rtl/vga_timing_ctrl_param.sv | 198 +++++++++++++++++++
 tb/tb_vga_timing_ctrl_param.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_ctrl_param_if.sv
// Pixel-RAM and VGA-connector signal bundle for vga_timing_ctrl_param.
// master: the timing controller; slave: the RAM/connector side.
interface vga_timing_ctrl_param_if #(
    parameter int unsigned COLOR_W = 4,
    parameter int unsigned COL_W   = 10,
    parameter int unsigned ROW_W   = 9,
    parameter int unsigned FCNT_W  = 8
);
    logic [3*COLOR_W-1:0] d_in;
    logic [ROW_W-1:0]     row_addr;
    logic [COL_W-1:0]     col_addr;
    logic                 rdn;
    logic [COLOR_W-1:0]   r;
    logic [COLOR_W-1:0]   g;
    logic [COLOR_W-1:0]   b;
    logic                 hs;
    logic                 vs;
    logic                 de;
    logic                 frame_start;
    logic                 line_start;
    logic [FCNT_W-1:0]    frame_cnt;

    modport master (
        input  d_in,
        output row_addr, col_addr, rdn, r, g, b, hs, vs, de, frame_start, line_start, frame_cnt
    );

    modport slave (
        output d_in,
        input  row_addr, col_addr, rdn, r, g, b, hs, vs, de, frame_start, line_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_ctrl_param.sv
// Parameterised VGA timing generator and pixel fetcher with a two-stage output pipeline.
// Defining VGA_TEST_PATTERN_EN adds a pattern_en input that replaces pixels with colour bars.
module vga_timing_ctrl_param #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned COL_W    = 10,
    parameter int unsigned ROW_W    = 9,
    parameter int unsigned FCNT_W   = 8
) (
    input  logic vga_clk,
    input  logic clrn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic pattern_en,
`endif
    vga_timing_ctrl_param_if.master io_vga
);
    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned H_START = H_SYNC + H_BP;
    localparam int unsigned V_START = V_SYNC + V_BP;
    localparam int unsigned H_END   = H_START + H_ACTIVE;
    localparam int unsigned V_END   = V_START + V_ACTIVE;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);

    // Timing counters
    logic [HCW-1:0] r_h_count;
    logic [HCW-1:0] w_h_next;
    logic [VCW-1:0] r_v_count;
    logic [VCW-1:0] w_v_next;

    always_comb begin
        w_h_next = r_h_count + 1'b1;
        w_v_next = r_v_count;
        if (32'(r_h_count) == H_TOTAL - 1) begin
            w_h_next = '0;
            if (32'(r_v_count) == V_TOTAL - 1) begin
                w_v_next = '0;
            end else begin
                w_v_next = r_v_count + 1'b1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_h_count <= '0;
            r_v_count <= '0;
        end else begin
            r_h_count <= w_h_next;
            r_v_count <= w_v_next;
        end
    end

    // Region decode; compares done at 32 bits so a zero front porch cannot overflow.
    logic w_h_sync;
    logic w_v_sync;
    logic w_active;
    logic w_rdn_d;
    logic [COL_W-1:0] w_col_d;
    logic [ROW_W-1:0] w_row_d;

    always_comb begin
        w_h_sync = 32'(r_h_count) < H_SYNC;
        w_v_sync = 32'(r_v_count) < V_SYNC;
        w_active = (32'(r_h_count) >= H_START) && (32'(r_h_count) < H_END) &&
                   (32'(r_v_count) >= V_START) && (32'(r_v_count) < V_END);
        w_col_d  = COL_W'(32'(r_h_count) - H_START);
        w_row_d  = ROW_W'(32'(r_v_count) - V_START);
`ifdef VGA_TEST_PATTERN_EN
        w_rdn_d  = ~w_active | pattern_en;
`else
        w_rdn_d  = ~w_active;
`endif
    end

    // Stage 1: RAM address and read strobe, plus sync levels carried alongside
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_rdn;
    logic             r_act1;
    logic             r_hs1;
    logic             r_vs1;
`ifdef VGA_TEST_PATTERN_EN
    logic             r_pat1;
`endif

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_col  <= '0;
            r_row  <= '0;
            r_rdn  <= 1'b1;
            r_act1 <= 1'b0;
            r_hs1  <= ~HS_POL;
            r_vs1  <= ~VS_POL;
        end else begin
            r_col  <= w_col_d;
            r_row  <= w_row_d;
            r_rdn  <= w_rdn_d;
            r_act1 <= w_active;
            r_hs1  <= w_h_sync ? HS_POL : ~HS_POL;
            r_vs1  <= w_v_sync ? VS_POL : ~VS_POL;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_pat1 <= 1'b0;
        end else begin
            r_pat1 <= pattern_en;
        end
    end

    localparam int unsigned BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    logic [2:0] w_bar;
    assign w_bar = 3'(32'(r_col) / BAR_W);
`endif

    // Stage 2 next-state: pixel data, enable and strobes
    logic [3*COLOR_W-1:0] w_rgb_d;
    logic                 w_ls_d;
    logic                 w_fs_d;

    always_comb begin
        w_rgb_d = '0;
        if (!r_rdn) begin
            w_rgb_d = io_vga.d_in;
        end
`ifdef VGA_TEST_PATTERN_EN
        if (r_act1 && r_pat1) begin
            w_rgb_d = {{COLOR_W{w_bar[2]}}, {COLOR_W{w_bar[1]}}, {COLOR_W{w_bar[0]}}};
        end
`endif
        w_ls_d = r_act1 && (r_col == '0);
        w_fs_d = w_ls_d && (r_row == '0);
    end

    logic [COLOR_W-1:0] r_r;
    logic [COLOR_W-1:0] r_g;
    logic [COLOR_W-1:0] r_b;
    logic               r_de;
    logic               r_hs;
    logic               r_vs;
    logic               r_ls;
    logic               r_fs;
    logic [FCNT_W-1:0]  r_fcnt;

    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            r_r    <= '0;
            r_g    <= '0;
            r_b    <= '0;
            r_de   <= 1'b0;
            r_hs   <= ~HS_POL;
            r_vs   <= ~VS_POL;
            r_ls   <= 1'b0;
            r_fs   <= 1'b0;
            r_fcnt <= '0;
        end else begin
            r_r  <= w_rgb_d[COLOR_W-1:0];
            r_g  <= w_rgb_d[2*COLOR_W-1:COLOR_W];
            r_b  <= w_rgb_d[3*COLOR_W-1:2*COLOR_W];
            r_de <= r_act1;
            r_hs <= r_hs1;
            r_vs <= r_vs1;
            r_ls <= w_ls_d;
            r_fs <= w_fs_d;
            // Counter updates on the same edge that raises frame_start
            if (w_fs_d) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
        end
    end

    assign io_vga.col_addr    = r_col;
    assign io_vga.row_addr    = r_row;
    assign io_vga.rdn         = r_rdn;
    assign io_vga.r           = r_r;
    assign io_vga.g           = r_g;
    assign io_vga.b           = r_b;
    assign io_vga.de          = r_de;
    assign io_vga.hs          = r_hs;
    assign io_vga.vs          = r_vs;
    assign io_vga.line_start  = r_ls;
    assign io_vga.frame_start = r_fs;
    assign io_vga.frame_cnt   = r_fcnt;

endmodule

// File: tb/tb_vga_timing_ctrl_param.sv
// Directed table-driven bench: default 640x480 timing instance plus a tiny-timing instance.
// n = number of rising edges since reset release; outputs sampled on the falling edge.
module tb_vga_timing_ctrl_param;

    typedef struct {
        int          n;
        logic        rdn;
        logic [31:0] col;
        logic [31:0] row;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic [31:0] fcnt;
        logic [31:0] rgb;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clrn_d;
    logic clrn_s;
`ifdef VGA_TEST_PATTERN_EN
    logic pat_d;
    logic pat_s;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vga_timing_ctrl_param_if #(.COLOR_W(4), .COL_W(10), .ROW_W(9), .FCNT_W(8)) bus_d ();
    vga_timing_ctrl_param_if #(.COLOR_W(2), .COL_W(3), .ROW_W(2), .FCNT_W(2)) bus_s ();

    // Pixel RAM models: combinational reads of the current address
    assign bus_d.d_in = 12'(bus_d.col_addr);
    assign bus_s.d_in = {1'b1, bus_s.row_addr, bus_s.col_addr};

    vga_timing_ctrl_param u_dut_def (
        .vga_clk    (clk),
        .clrn       (clrn_d),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en (pat_d),
`endif
        .io_vga     (bus_d)
    );

    vga_timing_ctrl_param #(
        .H_SYNC(2), .H_BP(1), .H_ACTIVE(8), .H_FP(1),
        .V_SYNC(1), .V_BP(1), .V_ACTIVE(4), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b0),
        .COLOR_W(2), .COL_W(3), .ROW_W(2), .FCNT_W(2)
    ) u_dut_small (
        .vga_clk    (clk),
        .clrn       (clrn_s),
`ifdef VGA_TEST_PATTERN_EN
        .pattern_en (pat_s),
`endif
        .io_vga     (bus_s)
    );

    task automatic check(input string name, input int n, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s n=%0d: got %0d, required %0d", name, n, act, exp);
        end
    endtask

    task automatic cmp_vec(input string tag, input vec_t a, input vec_t e);
        check({tag, "_rdn"},  e.n, 32'(a.rdn), 32'(e.rdn));
        check({tag, "_col"},  e.n, a.col, e.col);
        check({tag, "_row"},  e.n, a.row, e.row);
        check({tag, "_hs"},   e.n, 32'(a.hs), 32'(e.hs));
        check({tag, "_vs"},   e.n, 32'(a.vs), 32'(e.vs));
        check({tag, "_de"},   e.n, 32'(a.de), 32'(e.de));
        check({tag, "_fs"},   e.n, 32'(a.fs), 32'(e.fs));
        check({tag, "_ls"},   e.n, 32'(a.ls), 32'(e.ls));
        check({tag, "_fcnt"}, e.n, a.fcnt, e.fcnt);
        check({tag, "_rgb"},  e.n, a.rgb, e.rgb);
    endtask

    function automatic vec_t snap_def(input int n);
        vec_t v;
        v.n = n; v.rdn = bus_d.rdn; v.col = 32'(bus_d.col_addr); v.row = 32'(bus_d.row_addr);
        v.hs = bus_d.hs; v.vs = bus_d.vs; v.de = bus_d.de;
        v.fs = bus_d.frame_start; v.ls = bus_d.line_start; v.fcnt = 32'(bus_d.frame_cnt);
        v.rgb = 32'({bus_d.b, bus_d.g, bus_d.r});
        return v;
    endfunction

    function automatic vec_t snap_small(input int n);
        vec_t v;
        v.n = n; v.rdn = bus_s.rdn; v.col = 32'(bus_s.col_addr); v.row = 32'(bus_s.row_addr);
        v.hs = bus_s.hs; v.vs = bus_s.vs; v.de = bus_s.de;
        v.fs = bus_s.frame_start; v.ls = bus_s.line_start; v.fcnt = 32'(bus_s.frame_cnt);
        v.rgb = 32'({bus_s.b, bus_s.g, bus_s.r});
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Field order: n, rdn, col, row, hs, vs, de, fs, ls, fcnt, rgb
    vec_t td[12];
    vec_t ts[15];

    int ti, hs_low, vs_low, hs_high, de_cnt, ls_cnt, fs_cnt, rgb_bad, k, c;
`ifdef VGA_TEST_PATTERN_EN
    int rdn_low;
`endif

    initial begin
        td = '{
            '{0,     1, 0,    0,   1, 1, 0, 0, 0, 0, 0},
            '{2,     1, 881,  477, 0, 0, 0, 0, 0, 0, 0},
            '{97,    1, 976,  477, 0, 0, 0, 0, 0, 0, 0},
            '{98,    1, 977,  477, 1, 0, 0, 0, 0, 0, 0},
            '{1601,  1, 880,  479, 1, 0, 0, 0, 0, 0, 0},
            '{1602,  1, 881,  479, 0, 1, 0, 0, 0, 0, 0},
            '{28144, 1, 1023, 0,   1, 1, 0, 0, 0, 0, 0},
            '{28145, 0, 0,    0,   1, 1, 0, 0, 0, 0, 0},
            '{28146, 0, 1,    0,   1, 1, 1, 1, 1, 1, 0},
            '{28147, 0, 2,    0,   1, 1, 1, 0, 0, 1, 1},
            '{28785, 1, 640,  0,   1, 1, 1, 0, 0, 1, 639},
            '{28946, 0, 1,    1,   1, 1, 1, 0, 1, 1, 0}
        };
        ts = '{
            '{0,   1, 0, 0, 0, 1, 0, 0, 0, 0, 0},
            '{1,   1, 5, 2, 0, 1, 0, 0, 0, 0, 0},
            '{2,   1, 6, 2, 1, 0, 0, 0, 0, 0, 0},
            '{4,   1, 0, 2, 0, 0, 0, 0, 0, 0, 0},
            '{14,  1, 6, 3, 1, 1, 0, 0, 0, 0, 0},
            '{28,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0},
            '{29,  0, 1, 0, 0, 1, 1, 1, 1, 1, 32},
            '{36,  1, 0, 0, 0, 1, 1, 0, 0, 1, 39},
            '{37,  1, 5, 1, 0, 1, 0, 0, 0, 1, 0},
            '{38,  1, 6, 1, 1, 1, 0, 0, 0, 1, 0},
            '{41,  0, 1, 1, 0, 1, 1, 0, 1, 1, 40},
            '{113, 0, 1, 0, 0, 1, 1, 1, 1, 2, 32},
            '{197, 0, 1, 0, 0, 1, 1, 1, 1, 3, 32},
            '{281, 0, 1, 0, 0, 1, 1, 1, 1, 0, 32},
            '{365, 0, 1, 0, 0, 1, 1, 1, 1, 1, 32}
        };

        clrn_d = 1'b0;
        clrn_s = 1'b0;
`ifdef VGA_TEST_PATTERN_EN
        pat_d = 1'b0;
        pat_s = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // ---- default 640x480 timing ----
        clrn_d = 1'b1;
        ti = 0; hs_low = 0; vs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; rgb_bad = 0;
        for (int n = 0; n <= 29750; n++) begin
            if (n > 0) step();
            if (ti < 12 && td[ti].n == n) begin
                cmp_vec("def", snap_def(n), td[ti]);
                ti++;
            end
            if (n >= 2 && n <= 801 && !bus_d.hs) hs_low++;
            if (n >= 2 && n <= 1700 && !bus_d.vs) vs_low++;
            if (n >= 28146 && n <= 28945 && bus_d.de) de_cnt++;
            if (n >= 28146 && n <= 29745) begin
                if (bus_d.line_start) ls_cnt++;
                if (bus_d.frame_start) fs_cnt++;
            end
            if (!bus_d.de && {bus_d.b, bus_d.g, bus_d.r} !== 12'd0) rgb_bad++;
            if (bus_d.de && {bus_d.b, bus_d.g, bus_d.r} !== 12'((n - 2) % 800 - 144)) rgb_bad++;
        end
        check("def_hs_low_line", 0, hs_low, 96);
        check("def_vs_low", 0, vs_low, 1600);
        check("def_de_per_line", 0, de_cnt, 640);
        check("def_ls_two_lines", 0, ls_cnt, 2);
        check("def_fs_two_lines", 0, fs_cnt, 1);
        check("def_rgb_model", 0, rgb_bad, 0);

        // ---- small timing: 12-cycle lines, 7-line frames ----
        clrn_s = 1'b1;
        ti = 0; hs_high = 0; vs_low = 0; de_cnt = 0; ls_cnt = 0; fs_cnt = 0; rgb_bad = 0;
        for (int n = 0; n <= 370; n++) begin
            if (n > 0) step();
            if (ti < 15 && ts[ti].n == n) begin
                cmp_vec("small", snap_small(n), ts[ti]);
                ti++;
            end
            if (n >= 2 && n <= 85) begin
                if (bus_s.hs) hs_high++;
                if (!bus_s.vs) vs_low++;
                if (bus_s.de) de_cnt++;
                if (bus_s.line_start) ls_cnt++;
                if (bus_s.frame_start) fs_cnt++;
            end
            c = (n - 2) % 84;
            if (!bus_s.de && {bus_s.b, bus_s.g, bus_s.r} !== 6'd0) rgb_bad++;
            if (bus_s.de && {bus_s.b, bus_s.g, bus_s.r} !==
                6'(32 + (c / 12 - 2) * 8 + (c % 12 - 3))) rgb_bad++;
        end
        check("small_hs_high_frame", 0, hs_high, 14);
        check("small_vs_low_frame", 0, vs_low, 12);
        check("small_de_frame", 0, de_cnt, 32);
        check("small_ls_frame", 0, ls_cnt, 4);
        check("small_fs_frame", 0, fs_cnt, 1);
        check("small_rgb_model", 0, rgb_bad, 0);

        // ---- asynchronous reset in the middle of a visible line ----
        clrn_s = 1'b0;
        #1;
        clrn_s = 1'b1;
        repeat (41) step();
        check("rst_pre_de", 41, 32'(bus_s.de), 1);
        check("rst_pre_rdn", 41, 32'(bus_s.rdn), 0);
        #1;
        clrn_s = 1'b0;
        #1;
        cmp_vec("rst_async", snap_small(0), ts[0]);
        #1;
        clrn_s = 1'b1;
        k = 0;
        while (!bus_s.frame_start && k < 200) begin
            step();
            k++;
        end
        check("rst_fs_latency", k, k, 29);
        check("rst_fcnt_after", k, 32'(bus_s.frame_cnt), 1);

`ifdef VGA_TEST_PATTERN_EN
        // ---- colour bars: one pixel per bar at H_ACTIVE = 8 ----
        pat_s = 1'b1;
        clrn_s = 1'b0;
        #1;
        clrn_s = 1'b1;
        rdn_low = 0;
        for (int n = 0; n <= 40; n++) begin
            if (n > 0) step();
            if (!bus_s.rdn) rdn_low++;
            if (n == 29) check("pat_rgb_k0", n, 32'({bus_s.b, bus_s.g, bus_s.r}), 0);
            if (n == 30) check("pat_rgb_k1", n, 32'({bus_s.b, bus_s.g, bus_s.r}), 3);
            if (n == 31) check("pat_rgb_k2", n, 32'({bus_s.b, bus_s.g, bus_s.r}), 12);
            if (n == 36) check("pat_rgb_k7", n, 32'({bus_s.b, bus_s.g, bus_s.r}), 63);
            if (n == 29) check("pat_de", n, 32'(bus_s.de), 1);
            if (n == 37) check("pat_de_off", n, 32'(bus_s.de), 0);
        end
        check("pat_rdn_low", 0, rdn_low, 0);
        pat_s = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
